// File: rtl/uv_dbg_cmd_if.sv
// Inbound/outbound byte streams and debug request/response channel of uv_dbg_cmd.
// master: the command sequencer; slave: host byte link together with the debug slave.
interface uv_dbg_cmd_if #(
   parameter int unsigned ALEN = 12,
   parameter int unsigned DLEN = 32,
   parameter int unsigned MLEN = DLEN / 8
);
   logic            rx_vld;
   logic            rx_rdy;
   logic [7:0]      rx_data;

   logic            tx_vld;
   logic            tx_rdy;
   logic [7:0]      tx_data;

   logic            dbg_req_vld;
   logic            dbg_req_rdy;
   logic            dbg_req_read;
   logic [ALEN-1:0] dbg_req_addr;
   logic [MLEN-1:0] dbg_req_mask;
   logic [DLEN-1:0] dbg_req_data;

   logic            dbg_rsp_vld;
   logic            dbg_rsp_rdy;
   logic [1:0]      dbg_rsp_excp;
   logic [DLEN-1:0] dbg_rsp_data;

   modport master (
      input  rx_vld, rx_data,
      output rx_rdy,
      output tx_vld, tx_data,
      input  tx_rdy,
      output dbg_req_vld, dbg_req_read, dbg_req_addr, dbg_req_mask, dbg_req_data,
      input  dbg_req_rdy,
      input  dbg_rsp_vld, dbg_rsp_excp, dbg_rsp_data,
      output dbg_rsp_rdy
   );

   modport slave (
      output rx_vld, rx_data,
      input  rx_rdy,
      input  tx_vld, tx_data,
      output tx_rdy,
      input  dbg_req_vld, dbg_req_read, dbg_req_addr, dbg_req_mask, dbg_req_data,
      output dbg_req_rdy,
      output dbg_rsp_vld, dbg_rsp_excp, dbg_rsp_data,
      input  dbg_rsp_rdy
   );
endinterface

// File: rtl/uv_dbg_cmd.sv
// Byte-stream debug command sequencer: parses CMD/ADDR/DATA frames, issues one debug
// request, and returns a status byte (plus read data) on the outbound stream.
module uv_dbg_cmd #(
   parameter int unsigned ALEN = 12,
   parameter int unsigned DLEN = 32,
   parameter int unsigned MLEN = DLEN / 8,
   parameter int unsigned TMO  = 1024
) (
   input  logic         clk,
   input  logic         rst,
   uv_dbg_cmd_if.master bus_if,
   output logic         busy_o
);
   localparam int unsigned NBYTES = DLEN / 8;
   localparam int unsigned TW     = $clog2(TMO);
   localparam int unsigned OW     = $clog2(DLEN);

   localparam logic [7:0] STS_TMO = 8'hE0;
   localparam logic [7:0] STS_BAD = 8'hF0;

   typedef enum logic [2:0] {
      S_CMD,
      S_ADDR,
      S_DATA,
      S_REQ,
      S_RSP,
      S_TX_STS,
      S_TX_DAT
   } state_e;

   state_e          state_q;
   logic [2:0]      idx_q;
   logic [TW-1:0]   tmo_q;
   logic            read_q;
   logic [MLEN-1:0] mask_q;
   logic [ALEN-1:0] addr_q;
   logic [DLEN-1:0] data_q;
   logic [7:0]      sts_q;

   logic          rx_hs;
   logic          tx_hs;
   logic          tmo_hit;
   logic          last_data;
   logic [OW-1:0] byte_off;

   assign rx_hs     = bus_if.rx_vld & bus_if.rx_rdy;
   assign tx_hs     = bus_if.tx_vld & bus_if.tx_rdy;
   // Abort on the idle cycle that would bring the gap counter to TMO-1.
   assign tmo_hit   = (tmo_q == TW'(TMO - 2));
   assign last_data = (idx_q == 3'(NBYTES - 1));
   assign byte_off  = OW'({idx_q, 3'b000});

   // Frame parser, request/response sequencing and reply serializer.
   // The second address byte supplies bits ALEN-1:8, so ALEN must lie in 9..16.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_CMD;
         idx_q   <= '0;
         tmo_q   <= '0;
         read_q  <= 1'b0;
         mask_q  <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         sts_q   <= '0;
      end else begin
         case (state_q)
            S_CMD: begin
               if (rx_hs) begin
                  idx_q <= '0;
                  if (bus_if.rx_data[6:4] != 3'b000) begin
                     sts_q   <= STS_BAD;
                     state_q <= S_TX_STS;
                  end else begin
                     read_q  <= bus_if.rx_data[7];
                     mask_q  <= bus_if.rx_data[MLEN-1:0];
                     tmo_q   <= '0;
                     state_q <= S_ADDR;
                  end
               end
            end

            S_ADDR: begin
               if (rx_hs) begin
                  tmo_q <= '0;
                  if (idx_q == 3'd0) addr_q[7:0] <= bus_if.rx_data;
                  else               addr_q[ALEN-1:8] <= bus_if.rx_data[ALEN-9:0];
                  if (idx_q == 3'd1) begin
                     idx_q   <= '0;
                     state_q <= read_q ? S_REQ : S_DATA;
                  end else begin
                     idx_q <= idx_q + 3'd1;
                  end
               end else if (tmo_hit) begin
                  sts_q   <= STS_TMO;
                  read_q  <= 1'b0;
                  idx_q   <= '0;
                  tmo_q   <= '0;
                  state_q <= S_TX_STS;
               end else begin
                  tmo_q <= tmo_q + TW'(1);
               end
            end

            S_DATA: begin
               if (rx_hs) begin
                  tmo_q                  <= '0;
                  data_q[byte_off +: 8]  <= bus_if.rx_data;
                  if (last_data) begin
                     idx_q   <= '0;
                     state_q <= S_REQ;
                  end else begin
                     idx_q <= idx_q + 3'd1;
                  end
               end else if (tmo_hit) begin
                  sts_q   <= STS_TMO;
                  read_q  <= 1'b0;
                  idx_q   <= '0;
                  tmo_q   <= '0;
                  state_q <= S_TX_STS;
               end else begin
                  tmo_q <= tmo_q + TW'(1);
               end
            end

            S_REQ: begin
               if (bus_if.dbg_req_rdy) begin
                  idx_q   <= '0;
                  state_q <= S_RSP;
               end
            end

            S_RSP: begin
               if (bus_if.dbg_rsp_vld) begin
                  sts_q   <= {6'b000000, bus_if.dbg_rsp_excp};
                  data_q  <= bus_if.dbg_rsp_data;
                  idx_q   <= '0;
                  state_q <= S_TX_STS;
               end
            end

            S_TX_STS: begin
               if (tx_hs) begin
                  idx_q   <= '0;
                  state_q <= (read_q && (sts_q == 8'h00)) ? S_TX_DAT : S_CMD;
               end
            end

            S_TX_DAT: begin
               if (tx_hs) begin
                  if (last_data) begin
                     idx_q   <= '0;
                     state_q <= S_CMD;
                  end else begin
                     idx_q <= idx_q + 3'd1;
                  end
               end
            end

            default: begin
               idx_q   <= '0;
               state_q <= S_CMD;
            end
         endcase
      end
   end

   // Handshake outputs decode straight from the state register.
   assign bus_if.rx_rdy = ~rst & ((state_q == S_CMD) | (state_q == S_ADDR) | (state_q == S_DATA));
   assign bus_if.tx_vld = (state_q == S_TX_STS) | (state_q == S_TX_DAT);
   assign bus_if.tx_data = (state_q == S_TX_STS) ? sts_q :
                           (state_q == S_TX_DAT) ? data_q[byte_off +: 8] : 8'h00;

   assign bus_if.dbg_req_vld  = (state_q == S_REQ);
   assign bus_if.dbg_req_read = read_q;
   assign bus_if.dbg_req_addr = addr_q;
   assign bus_if.dbg_req_mask = mask_q;
   assign bus_if.dbg_req_data = read_q ? '0 : data_q;
   assign bus_if.dbg_rsp_rdy  = (state_q == S_RSP);

   assign busy_o = (state_q != S_CMD);
endmodule

// File: tb/tb_uv_dbg_cmd.sv
// Directed bench for uv_dbg_cmd: frame-level reference model with request/tx scoreboards,
// plus literal expectations for each scenario, gap timeout timing and reset behaviour.
module tb_uv_dbg_cmd;
   localparam int unsigned ALEN = 12;
   localparam int unsigned DLEN = 32;
   localparam int unsigned MLEN = 4;
   localparam int unsigned TMO  = 16;

   typedef struct packed {
      logic        rd;
      logic [11:0] addr;
      logic [3:0]  mask;
      logic [31:0] data;
   } req_t;

   logic clk = 1'b0;
   logic rst;
   logic busy;

   uv_dbg_cmd_if #(.ALEN(ALEN), .DLEN(DLEN), .MLEN(MLEN)) vif ();

   uv_dbg_cmd #(.ALEN(ALEN), .DLEN(DLEN), .MLEN(MLEN), .TMO(TMO)) dut (
      .clk    (clk),
      .rst    (rst),
      .bus_if (vif),
      .busy_o (busy)
   );

   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   req_t exp_req_q[$];
   logic [7:0] exp_tx_q[$];
   logic [7:0] act_tx_q[$];
   req_t last_req;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Frame-level reference: what request and which reply bytes a complete frame must produce.
   function automatic void model_frame(input logic [7:0] fr[$], input logic [1:0] excp,
                                       input logic [31:0] rdata);
      req_t r;
      logic [7:0] c;
      c = fr[0];
      if (c[6:4] != 3'b000) begin
         exp_tx_q.push_back(8'hF0);
         return;
      end
      r.rd   = c[7];
      r.mask = c[3:0];
      r.addr = 12'({fr[2], fr[1]});
      if (r.rd) r.data = 32'h0;
      else      r.data = {fr[6], fr[5], fr[4], fr[3]};
      exp_req_q.push_back(r);
      exp_tx_q.push_back({6'b000000, excp});
      if (r.rd && excp == 2'b00)
         for (int i = 0; i < 4; i++) exp_tx_q.push_back(rdata[8*i +: 8]);
   endfunction

   // Scoreboard/monitor: checks every request and tx handshake, and stability under stall.
   bit   req_held_v = 0;
   req_t req_held;
   bit   tx_held_v = 0;
   logic [7:0] tx_held;
   initial begin
      req_t cur;
      req_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            req_held_v = 0;
            tx_held_v  = 0;
         end else begin
            if (vif.dbg_req_vld) begin
               cur = {vif.dbg_req_read, vif.dbg_req_addr, vif.dbg_req_mask, vif.dbg_req_data};
               if (req_held_v) chk("req fields stable", 64'(cur), 64'(req_held));
               if (vif.dbg_req_rdy) begin
                  req_held_v = 0;
                  if (exp_req_q.size() == 0) begin
                     chk("unexpected req", 64'(vif.dbg_req_vld), 64'(0));
                  end else begin
                     e = exp_req_q.pop_front();
                     chk("req read", 64'(cur.rd), 64'(e.rd));
                     chk("req addr", 64'(cur.addr), 64'(e.addr));
                     chk("req mask", 64'(cur.mask), 64'(e.mask));
                     chk("req data", 64'(cur.data), 64'(e.data));
                     last_req = cur;
                  end
               end else begin
                  req_held_v = 1;
                  req_held   = cur;
               end
            end else begin
               if (req_held_v) chk("req vld held", 64'(vif.dbg_req_vld), 64'(1));
               req_held_v = 0;
            end

            if (vif.tx_vld) begin
               if (tx_held_v) chk("tx data stable", 64'(vif.tx_data), 64'(tx_held));
               if (vif.tx_rdy) begin
                  tx_held_v = 0;
                  act_tx_q.push_back(vif.tx_data);
                  if (exp_tx_q.size() == 0) chk("unexpected tx", 64'(vif.tx_vld), 64'(0));
                  else chk("tx byte", 64'(vif.tx_data), 64'(exp_tx_q.pop_front()));
               end else begin
                  tx_held_v = 1;
                  tx_held   = vif.tx_data;
               end
            end else begin
               if (tx_held_v) chk("tx vld held", 64'(vif.tx_vld), 64'(1));
               tx_held_v = 0;
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      vif.rx_vld  = 1'b1;
      vif.rx_data = b;
      while (!vif.rx_rdy && n < 100) begin tick(); n++; end
      if (n >= 100) chk("rx accept wait", 64'(vif.rx_rdy), 64'(1));
      tick();
      vif.rx_vld  = 1'b0;
      vif.rx_data = 8'h00;
   endtask

   task automatic serve_req(input int stall);
      int n = 0;
      while (!vif.dbg_req_vld && n < 50) begin tick(); n++; end
      if (n >= 50) begin
         chk("req wait", 64'(vif.dbg_req_vld), 64'(1));
         return;
      end
      chk("req latency", 64'(n), 64'(0));
      chk("rx_rdy in REQ", 64'(vif.rx_rdy), 64'(0));
      repeat (stall) tick();
      vif.dbg_req_rdy = 1'b1;
      tick();
      vif.dbg_req_rdy = 1'b0;
   endtask

   task automatic serve_rsp(input logic [1:0] excp, input logic [31:0] rdata);
      chk("rsp_rdy in RSP", 64'(vif.dbg_rsp_rdy), 64'(1));
      vif.dbg_rsp_vld  = 1'b1;
      vif.dbg_rsp_excp = excp;
      vif.dbg_rsp_data = rdata;
      tick();
      vif.dbg_rsp_vld  = 1'b0;
      vif.dbg_rsp_excp = 2'b00;
      vif.dbg_rsp_data = 32'h0;
      chk("tx_vld after rsp", 64'(vif.tx_vld), 64'(1));
   endtask

   task automatic drain_tx(input bit toggle);
      int n = 0;
      vif.tx_rdy = !toggle;
      while (busy && n < 200) begin
         tick();
         if (toggle) vif.tx_rdy = ~vif.tx_rdy;
         n++;
      end
      if (n >= 200) chk("drain wait busy", 64'(busy), 64'(0));
      vif.tx_rdy = 1'b0;
   endtask

   task automatic run_frame(input logic [7:0] fr[$], input logic [1:0] excp,
                            input logic [31:0] rdata, input int stall, input bit toggle,
                            input int gap);
      logic [7:0] c;
      c = fr[0];
      act_tx_q.delete();
      model_frame(fr, excp, rdata);
      foreach (fr[i]) begin
         send_byte(fr[i]);
         if (i < fr.size() - 1) repeat (gap) tick();
      end
      if (c[6:4] == 3'b000) begin
         serve_req(stall);
         serve_rsp(excp, rdata);
      end
      drain_tx(toggle);
      chk("pending tx", 64'(exp_tx_q.size()), 64'(0));
      chk("pending req", 64'(exp_req_q.size()), 64'(0));
   endtask

   task automatic run_timeout(input logic [7:0] fr[$]);
      act_tx_q.delete();
      exp_tx_q.push_back(8'hE0);
      foreach (fr[i]) send_byte(fr[i]);
      repeat (TMO - 2) tick();
      chk("tmo tx_vld early", 64'(vif.tx_vld), 64'(0));
      tick();
      chk("tmo tx_vld", 64'(vif.tx_vld), 64'(1));
      chk("tmo tx_data", 64'(vif.tx_data), 64'(8'hE0));
      chk("tmo rx_rdy", 64'(vif.rx_rdy), 64'(0));
      drain_tx(1'b0);
      chk("pending tx", 64'(exp_tx_q.size()), 64'(0));
   endtask

   task automatic check_tx_lit(input string name, input logic [7:0] lit[$]);
      chk({name, " len"}, 64'(act_tx_q.size()), 64'(lit.size()));
      foreach (lit[i])
         if (i < act_tx_q.size()) chk(name, 64'(act_tx_q[i]), 64'(lit[i]));
   endtask

   initial begin
      logic [7:0] fr[$];
      logic [7:0] lit[$];

      rst              = 1'b1;
      vif.rx_vld       = 1'b0;
      vif.rx_data      = 8'h00;
      vif.tx_rdy       = 1'b0;
      vif.dbg_req_rdy  = 1'b0;
      vif.dbg_rsp_vld  = 1'b0;
      vif.dbg_rsp_excp = 2'b00;
      vif.dbg_rsp_data = 32'h0;
      repeat (3) tick();
      chk("rst tx_vld", 64'(vif.tx_vld), 64'(0));
      chk("rst tx_data", 64'(vif.tx_data), 64'(0));
      chk("rst req_vld", 64'(vif.dbg_req_vld), 64'(0));
      chk("rst rsp_rdy", 64'(vif.dbg_rsp_rdy), 64'(0));
      chk("rst busy", 64'(busy), 64'(0));
      chk("rst req_data", 64'(vif.dbg_req_data), 64'(0));
      rst = 1'b0;
      #1;
      chk("rx_rdy after rst", 64'(vif.rx_rdy), 64'(1));
      tick();

      // Write
      fr = '{8'h0F, 8'h34, 8'h02, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      run_frame(fr, 2'b00, 32'h0, 0, 1'b0, 0);
      lit = '{8'h00};
      check_tx_lit("write tx", lit);
      chk("write lit read", 64'(last_req.rd), 64'(0));
      chk("write lit addr", 64'(last_req.addr), 64'(12'h234));
      chk("write lit mask", 64'(last_req.mask), 64'(4'hF));
      chk("write lit data", 64'(last_req.data), 64'(32'hDEADBEEF));

      // Read
      fr = '{8'h8F, 8'h10, 8'h00};
      run_frame(fr, 2'b00, 32'hFFFFFFFF, 0, 1'b0, 0);
      lit = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      check_tx_lit("read tx", lit);
      chk("read lit addr", 64'(last_req.addr), 64'(12'h010));
      chk("read lit read", 64'(last_req.rd), 64'(1));
      chk("read lit data", 64'(last_req.data), 64'(0));

      // Read with exception
      run_frame(fr, 2'b10, 32'h12345678, 0, 1'b0, 0);
      lit = '{8'h02};
      check_tx_lit("read excp tx", lit);
      chk("read excp busy", 64'(busy), 64'(0));

      // Bad command, then a normal read
      fr = '{8'h40};
      run_frame(fr, 2'b00, 32'h0, 0, 1'b0, 0);
      lit = '{8'hF0};
      check_tx_lit("bad cmd tx", lit);
      fr = '{8'h83, 8'h21, 8'h0C};
      run_frame(fr, 2'b00, 32'hA5C31E07, 0, 1'b0, 0);
      lit = '{8'h00, 8'h07, 8'h1E, 8'hC3, 8'hA5};
      check_tx_lit("read after bad tx", lit);
      chk("read after bad mask", 64'(last_req.mask), 64'(4'h3));

      // Gap timeout in ADDR and in DATA
      fr = '{8'h0F, 8'h34};
      run_timeout(fr);
      lit = '{8'hE0};
      check_tx_lit("tmo addr tx", lit);
      fr = '{8'h03, 8'h00, 8'h01, 8'h11};
      run_timeout(fr);
      check_tx_lit("tmo data tx", lit);

      // Gaps just under the timeout must not abort
      fr = '{8'h06, 8'h55, 8'h05, 8'h01, 8'h02, 8'h03, 8'h04};
      run_frame(fr, 2'b00, 32'h0, 0, 1'b0, TMO - 3);
      chk("gap write data", 64'(last_req.data), 64'(32'h04030201));

      // Backpressure: stalled request, toggled tx_rdy, dropped upper address bits
      fr = '{8'h05, 8'hCD, 8'hAB, 8'h11, 8'h22, 8'h33, 8'h44};
      run_frame(fr, 2'b01, 32'h0, 5, 1'b1, 0);
      lit = '{8'h01};
      check_tx_lit("bp write tx", lit);
      chk("bp write addr", 64'(last_req.addr), 64'(12'hBCD));
      chk("bp write mask", 64'(last_req.mask), 64'(4'h5));
      fr = '{8'h8A, 8'hFF, 8'hFF};
      run_frame(fr, 2'b00, 32'h89ABCDEF, 5, 1'b1, 0);
      lit = '{8'h00, 8'hEF, 8'hCD, 8'hAB, 8'h89};
      check_tx_lit("bp read tx", lit);
      chk("bp read addr", 64'(last_req.addr), 64'(12'hFFF));

      // Reset while waiting for the response
      fr = '{8'h8F, 8'h44, 8'h03};
      act_tx_q.delete();
      model_frame(fr, 2'b00, 32'h0);
      foreach (fr[i]) send_byte(fr[i]);
      serve_req(0);
      chk("pre-rst rsp_rdy", 64'(vif.dbg_rsp_rdy), 64'(1));
      chk("pre-rst busy", 64'(busy), 64'(1));
      rst = 1'b1;
      #1;
      exp_tx_q.delete();
      chk("mid-rst busy", 64'(busy), 64'(0));
      chk("mid-rst rsp_rdy", 64'(vif.dbg_rsp_rdy), 64'(0));
      chk("mid-rst tx_vld", 64'(vif.tx_vld), 64'(0));
      chk("mid-rst tx_data", 64'(vif.tx_data), 64'(0));
      chk("mid-rst req_vld", 64'(vif.dbg_req_vld), 64'(0));
      chk("mid-rst req_addr", 64'(vif.dbg_req_addr), 64'(0));
      chk("mid-rst rx_rdy", 64'(vif.rx_rdy), 64'(0));
      tick();
      rst = 1'b0;
      #1;
      chk("post-rst rx_rdy", 64'(vif.rx_rdy), 64'(1));
      tick();

      fr = '{8'h81, 8'h02, 8'h00};
      run_frame(fr, 2'b00, 32'h00C0FFEE, 0, 1'b0, 0);
      lit = '{8'h00, 8'hEE, 8'hFF, 8'hC0, 8'h00};
      check_tx_lit("recovery read tx", lit);

      repeat (3) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global timeout: got running expected finished");
      $fatal(1, "global timeout");
   end
endmodule
